// File: rtl/pwm_seq_ctrl.sv
// Step-wise motor-command sequencer: fetches (command, control) word pairs from the
// PWM command ROM, holds each command for a tick count and inserts dead-time on reversal.
module pwm_seq_ctrl #(
    parameter int STEP_W     = 7,
    parameter int DIR_BIT    = 15,
    parameter int DEAD_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              stop,
    input  logic [STEP_W-1:0] loop_step,
    output logic [STEP_W:0]   rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       pwm_cmd,
    output logic              pwm_en,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_idx
);

    localparam int DEAD_W = (DEAD_TICKS < 2) ? 1 : $clog2(DEAD_TICKS + 1);
    localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_TICKS);
    localparam bit DEAD_ON = (DEAD_TICKS > 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F_CMD = 3'd1,
        F_CTL = 3'd2,
        L_CTL = 3'd3,
        DEAD  = 3'd4,
        RUN   = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state, state_nxt;

    // A programmed duration of zero still occupies one tick.
    function automatic logic [13:0] clamp_dur(input logic [13:0] d);
        return (d == 14'd0) ? 14'd1 : d;
    endfunction

    logic [STEP_W-1:0] ptr, ptr_nxt, loop_tgt, loop_tgt_nxt, step_idx_nxt, ptr_inc;
    logic [STEP_W:0]   rom_addr_nxt;
    logic [15:0]       cmd_next, cmd_next_nxt, pwm_cmd_nxt;
    logic              ctl_last, ctl_last_nxt, ctl_loop, ctl_loop_nxt;
    logic [13:0]       dur_val, dur_val_nxt, dur_cnt, dur_cnt_nxt;
    logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
    logic              pwm_en_nxt, busy_nxt, done_nxt;
    logic              abort, accept, dir_flip, dead_end, run_end;

    assign abort    = stop && (state != IDLE);
    assign accept   = (state == IDLE) && start && !stop;
    assign dir_flip = DEAD_ON && pwm_en && (cmd_next[DIR_BIT] != pwm_cmd[DIR_BIT]);
    assign dead_end = (state == DEAD) && tick && (dead_cnt == DEAD_W'(1));
    assign run_end  = (state == RUN) && tick && (dur_cnt == 14'd1);
    assign ptr_inc  = ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = F_CMD;
                F_CMD:   state_nxt = F_CTL;
                F_CTL:   state_nxt = L_CTL;
                L_CTL:   state_nxt = dir_flip ? DEAD : RUN;
                DEAD:    if (dead_end) state_nxt = RUN;
                RUN:     if (run_end) state_nxt = (ctl_last && !ctl_loop) ? DONE : F_CMD;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs and step context are registered; pwm_cmd/pwm_en simply hold during refetch.
    always_comb begin
        ptr_nxt      = ptr;
        loop_tgt_nxt = loop_tgt;
        rom_addr_nxt = rom_addr;
        cmd_next_nxt = cmd_next;
        ctl_last_nxt = ctl_last;
        ctl_loop_nxt = ctl_loop;
        dur_val_nxt  = dur_val;
        dur_cnt_nxt  = dur_cnt;
        dead_cnt_nxt = dead_cnt;
        pwm_cmd_nxt  = pwm_cmd;
        pwm_en_nxt   = pwm_en;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        step_idx_nxt = step_idx;
        if (abort) begin
            pwm_cmd_nxt = '0;
            pwm_en_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr_nxt      = '0;
                        loop_tgt_nxt = loop_step;
                        rom_addr_nxt = '0;
                        busy_nxt     = 1'b1;
                    end
                end
                F_CMD: rom_addr_nxt = {ptr, 1'b1};
                F_CTL: cmd_next_nxt = rom_data;
                L_CTL: begin
                    ctl_last_nxt = rom_data[15];
                    ctl_loop_nxt = rom_data[14];
                    dur_val_nxt  = clamp_dur(rom_data[13:0]);
                    if (dir_flip) begin
                        pwm_en_nxt   = 1'b0;
                        dead_cnt_nxt = DEAD_INIT;
                    end else begin
                        pwm_cmd_nxt  = cmd_next;
                        pwm_en_nxt   = 1'b1;
                        step_idx_nxt = ptr;
                        dur_cnt_nxt  = clamp_dur(rom_data[13:0]);
                    end
                end
                DEAD: begin
                    if (tick) begin
                        dead_cnt_nxt = dead_cnt - 1'b1;
                        if (dead_end) begin
                            pwm_cmd_nxt  = cmd_next;
                            pwm_en_nxt   = 1'b1;
                            step_idx_nxt = ptr;
                            dur_cnt_nxt  = dur_val;
                        end
                    end
                end
                RUN: begin
                    if (tick) begin
                        dur_cnt_nxt = dur_cnt - 1'b1;
                        if (run_end) begin
                            if (!ctl_last) begin
                                ptr_nxt      = ptr_inc;
                                rom_addr_nxt = {ptr_inc, 1'b0};
                            end else if (ctl_loop) begin
                                ptr_nxt      = loop_tgt;
                                rom_addr_nxt = {loop_tgt, 1'b0};
                            end else begin
                                pwm_cmd_nxt = '0;
                                pwm_en_nxt  = 1'b0;
                                busy_nxt    = 1'b0;
                                done_nxt    = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            loop_tgt <= '0;
            rom_addr <= '0;
            cmd_next <= '0;
            ctl_last <= 1'b0;
            ctl_loop <= 1'b0;
            dur_val  <= '0;
            dur_cnt  <= '0;
            dead_cnt <= '0;
            pwm_cmd  <= '0;
            pwm_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_idx <= '0;
        end else begin
            ptr      <= ptr_nxt;
            loop_tgt <= loop_tgt_nxt;
            rom_addr <= rom_addr_nxt;
            cmd_next <= cmd_next_nxt;
            ctl_last <= ctl_last_nxt;
            ctl_loop <= ctl_loop_nxt;
            dur_val  <= dur_val_nxt;
            dur_cnt  <= dur_cnt_nxt;
            dead_cnt <= dead_cnt_nxt;
            pwm_cmd  <= pwm_cmd_nxt;
            pwm_en   <= pwm_en_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            step_idx <= step_idx_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: directed program scenarios plus randomized programs, checked
// every clock against a timeline model built from the step/tick playback rules.
module tb_pwm_seq_ctrl;

    localparam int DEAD = 3;
    localparam int MAXN = 1024;

    logic        clk = 1'b0;
    logic        rst, tick, start, stop;
    logic [6:0]  loop_step;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data, pwm_cmd;
    logic        pwm_en, busy, done;
    logic [6:0]  step_idx;

    logic [15:0] rom [0:255];
    bit          tick_v  [MAXN];
    bit          start_v [MAXN];
    bit          stop_v  [MAXN];
    logic [25:0] exp_v   [MAXN];
    int          n_run, start_e, stop_x;
    logic [6:0]  prev_step, lstep;
    int          n_vec, n_err;

    pwm_seq_ctrl #(.STEP_W(7), .DIR_BIT(15), .DEAD_TICKS(DEAD)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .loop_step(loop_step), .rom_addr(rom_addr), .rom_data(rom_data),
        .pwm_cmd(pwm_cmd), .pwm_en(pwm_en), .busy(busy), .done(done),
        .step_idx(step_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        prev_step = 7'd0;
    endtask

    task automatic prepare_run(input int n, input int e, input int x);
        n_run = n; start_e = e; stop_x = x;
        for (int i = 0; i < MAXN; i++) begin
            tick_v[i] = 1'b0; start_v[i] = 1'b0; stop_v[i] = 1'b0;
        end
        if (e >= 0) start_v[e] = 1'b1;
        if (x >= 0) stop_v[x] = 1'b1;
    endtask

    task automatic finish_run();
        prev_step = exp_v[n_run-1][6:0];
        tick = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic fill(input int from, input bit b, input bit d, input bit en,
                        input logic [15:0] c, input logic [6:0] s);
        for (int k = from; k < n_run; k++) exp_v[k] = {b, d, en, c, s};
    endtask

    // Edge index of the m-th tick strictly after edge p (n_run if never).
    function automatic int nth_tick(input int p, input int m);
        int k = p;
        int cnt = 0;
        while (cnt < m) begin
            k++;
            if (k >= n_run) return n_run;
            if (tick_v[k]) cnt++;
        end
        return k;
    endfunction

    // Expected {busy, done, pwm_en, pwm_cmd, step_idx} after each clock edge.
    task automatic build_model();
        int s, a, p, t, d;
        logic [15:0] c, ctl, cur_cmd;
        logic cur_en;
        logic [6:0] cur_step;
        fill(0, 0, 0, 0, 16'h0, prev_step);
        if (start_e >= 0 && start_e != stop_x) begin
            fill(start_e, 1, 0, 0, 16'h0, prev_step);
            s = 0; a = start_e + 3; cur_en = 0; cur_cmd = 16'h0; cur_step = prev_step;
            while (a < n_run) begin
                c = rom[2*s]; ctl = rom[2*s+1];
                d = (ctl[13:0] == 14'd0) ? 1 : int'(ctl[13:0]);
                p = a;
                if (cur_en && (c[15] != cur_cmd[15]) && DEAD > 0) begin
                    fill(a, 1, 0, 0, cur_cmd, cur_step);
                    p = nth_tick(a, DEAD);
                end
                if (p >= n_run) break;
                cur_en = 1; cur_cmd = c; cur_step = 7'(s);
                fill(p, 1, 0, 1, c, cur_step);
                t = nth_tick(p, d);
                if (t >= n_run) break;
                if (!ctl[15]) begin
                    s = (s + 1) % 128; a = t + 3;
                end else if (ctl[14]) begin
                    s = int'(lstep); a = t + 3;
                end else begin
                    fill(t, 0, 1, 0, 16'h0, cur_step);
                    fill(t + 1, 0, 0, 0, 16'h0, cur_step);
                    break;
                end
            end
            if (stop_x > start_e && stop_x < n_run)
                fill(stop_x, 0, 0, 0, 16'h0, exp_v[stop_x-1][6:0]);
        end
    endtask

    task automatic step_cycle(input int k, output logic [25:0] obs);
        tick = tick_v[k]; start = start_v[k]; stop = stop_v[k];
        @(posedge clk);
        #1 obs = {busy, done, pwm_en, pwm_cmd, step_idx};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, pwm_en, pwm_cmd, step_idx, rom_addr} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_async got=%h exp=0", {busy, done, pwm_en, pwm_cmd, step_idx, rom_addr});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        prev_step = 7'd0;
        n_vec++;
        if ({busy, done, pwm_en, pwm_cmd, step_idx, rom_addr} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_release got=%h exp=0", {busy, done, pwm_en, pwm_cmd, step_idx, rom_addr});
        end
    endtask

    task automatic test_single_step();
        logic [25:0] obs;
        int dones = 0;
        do_reset(); clear_rom();
        rom[0] = 16'h1230; rom[1] = 16'h8005;
        lstep = 7'd0; loop_step = lstep;
        prepare_run(60, 2, -1);
        for (int k = 0; k < n_run; k++) tick_v[k] = (k % 5 == 0);
        build_model();
        for (int k = 0; k < n_run; k++) begin
            step_cycle(k, obs);
            n_vec++;
            if (obs !== exp_v[k]) begin
                n_err++;
                $display("FAIL single_step cyc=%0d got=%h exp=%h", k, obs, exp_v[k]);
            end
            if (done) dones++;
            if (k == 4 || k == 5) begin
                n_vec++;
                if (pwm_en !== (k == 5) || (k == 5 && pwm_cmd !== 16'h1230)) begin
                    n_err++;
                    $display("FAIL single_apply cyc=%0d got en=%b cmd=%h exp en=%b cmd=1230", k, pwm_en, pwm_cmd, k == 5);
                end
            end
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL single_done_count got=%0d exp=1", dones);
        end
        finish_run();
    endtask

    task automatic test_three_steps();
        logic [25:0] obs;
        int drops = 0;
        logic [2:0] seen = 3'b000;
        do_reset(); clear_rom();
        rom[0] = 16'h1111; rom[1] = 16'h0002;
        rom[2] = 16'h2222; rom[3] = 16'h0001;
        rom[4] = 16'h3333; rom[5] = 16'h8003;
        lstep = 7'd0; loop_step = lstep;
        prepare_run(60, 1, -1);
        for (int k = 0; k < n_run; k++) tick_v[k] = (k % 3 == 0);
        build_model();
        for (int k = 0; k < n_run; k++) begin
            step_cycle(k, obs);
            n_vec++;
            if (obs !== exp_v[k]) begin
                n_err++;
                $display("FAIL three_steps cyc=%0d got=%h exp=%h", k, obs, exp_v[k]);
            end
            if (k >= 4 && busy && !pwm_en) drops++;
            if (pwm_en && step_idx < 3) seen[step_idx[1:0]] = 1'b1;
        end
        n_vec++;
        if (drops !== 0 || seen !== 3'b111) begin
            n_err++;
            $display("FAIL three_en_steps got drops=%0d seen=%b exp drops=0 seen=111", drops, seen);
        end
        finish_run();
    endtask

    task automatic test_dir_flip();
        logic [25:0] obs;
        logic [25:0] prev_obs = '0;
        int dead_ticks = 0;
        bit new_seen = 0;
        do_reset(); clear_rom();
        rom[0] = 16'h1230; rom[1] = 16'h0002;
        rom[2] = 16'h9230; rom[3] = 16'h8002;
        lstep = 7'd0; loop_step = lstep;
        prepare_run(60, 1, -1);
        for (int k = 0; k < n_run; k++) tick_v[k] = (k % 3 == 0);
        build_model();
        for (int k = 0; k < n_run; k++) begin
            step_cycle(k, obs);
            n_vec++;
            if (obs !== exp_v[k]) begin
                n_err++;
                $display("FAIL dir_flip cyc=%0d got=%h exp=%h", k, obs, exp_v[k]);
            end
            if (k >= 5 && tick_v[k] && prev_obs[25] && !prev_obs[23]) dead_ticks++;
            if (pwm_en && pwm_cmd == 16'h9230) new_seen = 1;
            prev_obs = obs;
        end
        n_vec++;
        if (dead_ticks !== DEAD || !new_seen) begin
            n_err++;
            $display("FAIL dir_dead_ticks got=%0d applied=%b exp=%0d applied=1", dead_ticks, new_seen, DEAD);
        end
        finish_run();
    endtask

    task automatic test_loop_stop();
        logic [25:0] obs;
        int dones = 0;
        do_reset(); clear_rom();
        rom[0] = 16'h0100; rom[1] = 16'h0001;
        rom[2] = 16'h0200; rom[3] = 16'hC002;
        lstep = 7'd1; loop_step = lstep;
        prepare_run(80, 1, 70);
        for (int k = 0; k < n_run; k++) tick_v[k] = (k % 2 == 0);
        build_model();
        for (int k = 0; k < n_run; k++) begin
            step_cycle(k, obs);
            n_vec++;
            if (obs !== exp_v[k]) begin
                n_err++;
                $display("FAIL loop_stop cyc=%0d got=%h exp=%h", k, obs, exp_v[k]);
            end
            if (done) dones++;
        end
        n_vec++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL loop_no_done got=%0d exp=0", dones);
        end
        finish_run();
    endtask

    task automatic test_dur0_fetch_tick();
        logic [25:0] obs;
        int en_cycles = 0;
        do_reset(); clear_rom();
        rom[0] = 16'h0ABC; rom[1] = 16'h8000;
        lstep = 7'd0; loop_step = lstep;
        prepare_run(20, 2, -1);
        for (int k = 0; k < n_run; k++) tick_v[k] = 1'b1;
        build_model();
        for (int k = 0; k < n_run; k++) begin
            step_cycle(k, obs);
            n_vec++;
            if (obs !== exp_v[k]) begin
                n_err++;
                $display("FAIL dur0 cyc=%0d got=%h exp=%h", k, obs, exp_v[k]);
            end
            if (pwm_en) en_cycles++;
        end
        n_vec++;
        if (en_cycles !== 1) begin
            n_err++;
            $display("FAIL dur0_hold got=%0d cycles exp=1", en_cycles);
        end
        finish_run();
    endtask

    task automatic test_async_reset_mid_run();
        logic [25:0] obs;
        do_reset(); clear_rom();
        rom[0] = 16'h1230; rom[1] = 16'h8005;
        lstep = 7'd0; loop_step = lstep;
        prepare_run(40, 1, -1);
        for (int k = 0; k < n_run; k++) tick_v[k] = (k % 3 == 0);
        build_model();
        for (int k = 0; k < 10; k++) begin
            step_cycle(k, obs);
            n_vec++;
            if (obs !== exp_v[k]) begin
                n_err++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", k, obs, exp_v[k]);
            end
        end
        tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, pwm_en, pwm_cmd, step_idx, rom_addr} !== 34'h0) begin
            n_err++;
            $display("FAIL mid_run_reset got=%h exp=0", {busy, done, pwm_en, pwm_cmd, step_idx, rom_addr});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        prev_step = 7'd0;
        build_model();
        for (int k = 0; k < n_run; k++) begin
            step_cycle(k, obs);
            n_vec++;
            if (obs !== exp_v[k]) begin
                n_err++;
                $display("FAIL replay cyc=%0d got=%h exp=%h", k, obs, exp_v[k]);
            end
        end
        finish_run();
    endtask

    task automatic test_wrap();
        logic [25:0] obs;
        do_reset(); clear_rom();
        for (int s = 0; s < 128; s++) begin
            rom[2*s]   = {1'b0, 7'(s), 1'b1, 7'(s)};
            rom[2*s+1] = 16'h0001;
        end
        lstep = 7'd0; loop_step = lstep;
        prepare_run(600, 1, 590);
        for (int k = 0; k < n_run; k++) tick_v[k] = 1'b1;
        build_model();
        for (int k = 0; k < n_run; k++) begin
            step_cycle(k, obs);
            n_vec++;
            if (obs !== exp_v[k]) begin
                n_err++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", k, obs, exp_v[k]);
            end
        end
        finish_run();
    endtask

    task automatic test_random();
        logic [25:0] obs;
        int ns, e, x, k2;
        do_reset();
        for (int it = 0; it < 20; it++) begin
            clear_rom();
            ns = $urandom_range(1, 6);
            for (int s = 0; s < ns; s++) begin
                rom[2*s]   = 16'($urandom);
                rom[2*s+1] = {(s == ns - 1), 1'($urandom_range(0, 1)), 12'h0, 2'($urandom_range(0, 3))};
            end
            lstep = 7'($urandom_range(0, ns - 1)); loop_step = lstep;
            e = $urandom_range(1, 4);
            x = ($urandom_range(0, 4) < 2) ? int'($urandom_range(e, 199)) : -1;
            prepare_run(200, e, x);
            for (int k = 0; k < n_run; k++) tick_v[k] = ($urandom_range(0, 2) == 0);
            build_model();
            k2 = e + $urandom_range(1, 8);
            if (exp_v[k2-1][25]) start_v[k2] = 1'b1;
            for (int k = 0; k < n_run; k++) begin
                if (k == e + 2) loop_step = ~lstep;
                step_cycle(k, obs);
                n_vec++;
                if (obs !== exp_v[k]) begin
                    n_err++;
                    $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, k, obs, exp_v[k]);
                end
            end
            finish_run();
            if (exp_v[n_run-1][25]) do_reset();
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        tick = 1'b0; start = 1'b0; stop = 1'b0; loop_step = 7'd0; rst = 1'b0;
        prev_step = 7'd0; lstep = 7'd0;
        clear_rom();
        test_reset();
        test_single_step();
        test_three_steps();
        test_dir_flip();
        test_loop_stop();
        test_dur0_fetch_tick();
        test_async_reset_mid_run();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctrl.md
# pwm_seq_ctrl

Sequencer that plays a motor-command program out of the PWM command ROM and drives the PWM block's command input. The block replaces free-running address counting with step-wise playback: it fetches a (command, control) word pair per step, holds each command for a programmed number of ticks, and inserts a dead-time on direction reversal. It also supports start, abort, end-of-program and looping. It sits between the block-memory ROM and the PWM core, clocked on the system clock with a slow tick strobe as time base.

## Interface
- STEP_W, 7: step index width; ROM address width is STEP_W+1 (two words per step).
- DIR_BIT, 15: bit of the command word that carries direction.
- DEAD_TICKS, 3: ticks of forced-off output on a direction change (0 disables).

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-clk time-base strobe (e.g. 330 Hz enable)
- start  in  1  one-clk request to begin playback at step 0
- stop  in  1  one-clk abort request
- loop_step  in  STEP_W  loop target step, sampled on accepted start
- rom_addr  out  STEP_W+1  ROM word address (registered)
- rom_data  in  16  ROM read data, valid one clk after rom_addr is sampled
- pwm_cmd  out  16  command word to PWM core
- pwm_en  out  1  PWM output enable
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-clk pulse on normal program end
- step_idx  out  STEP_W  index of step currently applied

## Operation
- Word pair per step s: address 2s = PWM command (passed verbatim); 2s+1 = control: [15] last, [14] loop, [13:0] duration in ticks (0 treated as 1).
- States: IDLE, F_CMD, F_CTL, L_CTL, DEAD, RUN, DONE.
- IDLE: start → ptr=0, latch loop_step, rom_addr=0, busy=1, go F_CMD. start while busy ignored.
- F_CMD: rom_addr=2·ptr+1; go F_CTL.
- F_CTL: capture rom_data as cmd_next; go L_CTL.
- L_CTL: capture control word. If pwm_en=1, cmd_next[DIR_BIT]≠pwm_cmd[DIR_BIT], DEAD_TICKS>0 → pwm_en=0, dead_cnt=DEAD_TICKS, go DEAD. Else apply: pwm_cmd=cmd_next, pwm_en=1, step_idx=ptr, dur_cnt=max(duration,1), go RUN.
- DEAD: pwm_cmd holds old value, pwm_en=0; decrement on tick; on tick with dead_cnt=1 apply as above, go RUN.
- RUN: decrement dur_cnt on tick. On tick with dur_cnt=1: last=0 → ptr=ptr+1 (wraps 2^STEP_W−1→0), rom_addr=2·ptr_new, go F_CMD; last=1,loop=1 → ptr=loop target, go F_CMD; last=1,loop=0 → go DONE.
- During refetch pwm_cmd/pwm_en hold previous step values (no glitch).
- DONE: pwm_cmd=0, pwm_en=0, done=1 for one clk, busy=0, go IDLE.
- stop in any non-IDLE state: next edge → IDLE, pwm_cmd=0, pwm_en=0, busy=0, no done pulse. stop and start same clk in IDLE: stop wins (remain IDLE).
- Ticks in F_CMD/F_CTL/L_CTL are not counted.

## Timing
- Reset (async): state IDLE, rom_addr=0, pwm_cmd=0, pwm_en=0, busy=0, done=0, step_idx=0, all counters 0. Reset mid-playback behaves identically.
- Start sampled at edge E: busy high after E; cmd applied (pwm_en high) after E+3 (F_CMD, F_CTL, L_CTL).
- Step-to-step gap: 3 clk after the terminating tick edge, excluding dead-time.
- Step of duration D occupies exactly D ticks after the apply edge (first counted tick is the first one strictly after apply).
- Dead-time: exactly DEAD_TICKS ticks with pwm_en=0.
- done asserted the clk after the final tick edge.

## Test plan
- Single step: ROM[0]=16'h1230, ROM[1]=16'h8005, start → pwm_cmd=16'h1230 after 3 clk, held 5 ticks, then done pulse, pwm_cmd=0, busy=0.
- Three steps, same dir: durations 2,1,3 (last on step 2) → step_idx 0,1,2, pwm_en never drops, total 6 ticks.
- Direction flip: step0 16'h1230, step1 16'h9230, DEAD_TICKS=3 → pwm_en low exactly 3 ticks between steps, then pwm_cmd=16'h9230.
- Loop: 2 steps, step1 control 16'hC002, loop_step=1 → after step0, step1 repeats indefinitely; stop → IDLE within 1 clk, no done.
- Duration 0 and ticks in fetch states: control 16'h8000 → step holds 1 tick; tick asserted during F_CTL not counted.
- Async rst asserted in RUN mid-step → all outputs to reset values immediately; start after release replays from step 0.
